// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: ALU opcodes, branch conditions,
// forward selects and datapath width.
package pipeline_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared by the execute stage.
// Results wrap modulo 2^XLEN; shifts use the low five bits of srcB.
module alu
  import pipeline_pkg::*;
#(
  parameter int WIDTH = pipeline_pkg::XLEN
) (
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       aluControl,
  output logic [WIDTH-1:0] result
);

  logic lt;
  assign lt = $signed(srcA) < $signed(srcB);

  always_comb begin
    result = '0;
    case (aluControl)
      ALU_ADD: result = srcA + srcB;
      ALU_SUB: result = srcA - srcB;
      ALU_AND: result = srcA & srcB;
      ALU_OR:  result = srcA | srcB;
      ALU_XOR: result = srcA ^ srcB;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      ALU_SLL: result = srcA << srcB[4:0];
      ALU_SRL: result = srcA >> srcB[4:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: forwarding, ALU, branch resolve, fetch redirect,
// wrong-path annulment and the EX/MEM pipeline register.
module execute_cycle
  import pipeline_pkg::*;
#(
  parameter int XLEN         = pipeline_pkg::XLEN,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM
);

  localparam int CW = $clog2(SQUASH_DEPTH + 1);

  logic [XLEN-1:0] srcAE;
  logic [XLEN-1:0] writeDataE;
  logic [XLEN-1:0] srcBE;
  logic [XLEN-1:0] aluResultE;
  logic [CW-1:0]   squashCnt;
  logic            squash;
  logic            cond;
  logic            rawRedirect;

  always_comb begin
    srcAE = RD1E;
    case (ForwardAE)
      FWD_WB:  srcAE = ResultW;
      FWD_MEM: srcAE = ALUResultM;
      default: srcAE = RD1E;
    endcase
  end

  always_comb begin
    writeDataE = RD2E;
    case (ForwardBE)
      FWD_WB:  writeDataE = ResultW;
      FWD_MEM: writeDataE = ALUResultM;
      default: writeDataE = RD2E;
    endcase
  end

  assign srcBE = ALUSrcE ? ImmExtE : writeDataE;

  alu #(.WIDTH(XLEN)) u_alu (
    .srcA       (srcAE),
    .srcB       (srcBE),
    .aluControl (ALUControlE),
    .result     (aluResultE)
  );

  always_comb begin
    cond = 1'b0;
    case (Funct3E)
      BR_EQ:   cond = srcAE == writeDataE;
      BR_NE:   cond = srcAE != writeDataE;
      BR_LT:   cond = $signed(srcAE) < $signed(writeDataE);
      BR_GE:   cond = $signed(srcAE) >= $signed(writeDataE);
      BR_LTU:  cond = srcAE < writeDataE;
      BR_GEU:  cond = srcAE >= writeDataE;
      default: cond = 1'b0;
    endcase
  end

  assign PCTargetE   = PCE + ImmExtE;
  assign squash      = squashCnt != '0;
  assign rawRedirect = JumpE | (BranchE & cond);
  // Wrong-path instructions may themselves look like jumps; never act on them.
  assign PCSrcE      = rawRedirect & ~squash & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      squashCnt <= '0;
    end else if (squash) begin
      squashCnt <= squashCnt - CW'(1);
    end else if (rawRedirect) begin
      squashCnt <= CW'(SQUASH_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else begin
      RegWriteM  <= RegWriteE & ~squash;
      MemWriteM  <= MemWriteE & ~squash;
      ResultSrcM <= squash ? 2'b00 : ResultSrcE;
      ALUResultM <= aluResultE;
      WriteDataM <= writeDataE;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed testbench for execute_cycle: reset, ALU/forwarding,
// branch compare, redirect and wrong-path squash behaviour.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  task automatic idle();
    RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
    ALUSrcE = 0; ResultSrcE = 0; ALUControlE = 0; Funct3E = 0;
    RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0;
    RdE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    RegWriteE = 1; JumpE = 1; MemWriteE = 1; ResultSrcE = 2'b11;
    RD1E = 32'h55; PCPlus4E = 32'h44; RdE = 5'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      totalCnt++;
      if (PCSrcE !== 1'b0)
        $display("FAIL reset_pcsrc cyc%0d got %b want 0", i, PCSrcE);
      else passCnt++;
      totalCnt++;
      if ({RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
           WriteDataM, PCPlus4M, RdM} !== '0)
        $display("FAIL reset_m cyc%0d got %b%b %h %h %h %h %h want 0",
                 i, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
                 WriteDataM, PCPlus4M, RdM);
      else passCnt++;
    end
    rst = 0;
    JumpE = 0; MemWriteE = 0; ResultSrcE = 0;
    step();
    totalCnt++;
    if (RegWriteM !== 1'b1 || RdM !== 5'd7)
      $display("FAIL reset_release got rw=%b rd=%0d want rw=1 rd=7",
               RegWriteM, RdM);
    else passCnt++;
    idle();
  endtask

  task automatic test_alu_forward();
    idle();
    RD1E = 5; ResultW = 7; ForwardAE = 2'b01;
    ImmExtE = 3; ALUSrcE = 1; ALUControlE = 3'b000;
    PCPlus4E = 32'h1004; RdE = 5'd3;
    step();
    totalCnt++;
    if (ALUResultM !== 32'd10 || PCPlus4M !== 32'h1004 || RdM !== 5'd3)
      $display("FAIL fwd_wb got %h %h %0d want 0000000a 00001004 3",
               ALUResultM, PCPlus4M, RdM);
    else passCnt++;
    ForwardAE = 2'b10; ALUControlE = 3'b001; ImmExtE = 4;
    step();
    totalCnt++;
    if (ALUResultM !== 32'd6)
      $display("FAIL fwd_mem got %h want 00000006", ALUResultM);
    else passCnt++;
    // forward B path into WriteDataM
    ForwardAE = 2'b11; RD1E = 1; ForwardBE = 2'b10;
    RD2E = 32'hDEAD; ALUSrcE = 0; ALUControlE = 3'b000;
    step();
    totalCnt++;
    if (WriteDataM !== 32'd6 || ALUResultM !== 32'd7)
      $display("FAIL fwd_b got wd=%h alu=%h want 00000006 00000007",
               WriteDataM, ALUResultM);
    else passCnt++;
    idle();
  endtask

  task automatic test_alu_ops();
    logic [31:0] a [7];
    logic [31:0] b [7];
    logic [2:0]  op [7];
    logic [31:0] ex [7];
    a[0] = 32'hF0F0_1234; b[0] = 32'h0FF0_FF00; op[0] = 3'b010;
    ex[0] = 32'h00F0_1200;
    a[1] = 32'hF0F0_1234; b[1] = 32'h0FF0_FF00; op[1] = 3'b011;
    ex[1] = 32'hFFF0_FF34;
    a[2] = 32'hF0F0_1234; b[2] = 32'h0FF0_FF00; op[2] = 3'b100;
    ex[2] = 32'hFF00_ED34;
    a[3] = 32'd3;         b[3] = 32'd5;         op[3] = 3'b001;
    ex[3] = 32'hFFFF_FFFE;
    a[4] = 32'd1;         b[4] = 32'h24;        op[4] = 3'b110;
    ex[4] = 32'h10;
    a[5] = 32'h8000_0000; b[5] = 32'h21;        op[5] = 3'b111;
    ex[5] = 32'h4000_0000;
    a[6] = 32'd1;         b[6] = 32'hFFFF_FFFF; op[6] = 3'b101;
    ex[6] = 32'd0;
    idle();
    for (int i = 0; i < 7; i++) begin
      RD1E = a[i]; RD2E = b[i]; ALUControlE = op[i];
      step();
      totalCnt++;
      if (ALUResultM !== ex[i])
        $display("FAIL alu_op%0d got %h want %h", i, ALUResultM, ex[i]);
      else passCnt++;
    end
    idle();
  endtask

  task automatic test_signed();
    logic [2:0] f3 [8];
    logic       tk [8];
    idle();
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; BranchE = 1;
    f3[0] = 3'b100; tk[0] = 1;
    f3[1] = 3'b110; tk[1] = 0;
    f3[2] = 3'b101; tk[2] = 0;
    f3[3] = 3'b111; tk[3] = 1;
    f3[4] = 3'b000; tk[4] = 0;
    f3[5] = 3'b001; tk[5] = 1;
    f3[6] = 3'b010; tk[6] = 0;
    f3[7] = 3'b011; tk[7] = 0;
    for (int i = 0; i < 8; i++) begin
      Funct3E = f3[i];
      #1;
      totalCnt++;
      if (PCSrcE !== tk[i])
        $display("FAIL br_f3_%b got %b want %b", f3[i], PCSrcE, tk[i]);
      else passCnt++;
    end
    RD2E = 32'hFFFF_FFFF;
    Funct3E = 3'b000;
    #1;
    totalCnt++;
    if (PCSrcE !== 1'b1)
      $display("FAIL br_eq got %b want 1", PCSrcE);
    else passCnt++;
    BranchE = 0; RD2E = 32'd1; ALUControlE = 3'b101;
    step();
    totalCnt++;
    if (ALUResultM !== 32'd1)
      $display("FAIL slt got %h want 00000001", ALUResultM);
    else passCnt++;
    idle();
  endtask

  task automatic test_branch_squash();
    idle();
    PCE = 32'h100; ImmExtE = 32'h20; RD1E = 9; RD2E = 9;
    BranchE = 1; Funct3E = 3'b000;
    #1;
    totalCnt++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120)
      $display("FAIL beq got %b %h want 1 00000120", PCSrcE, PCTargetE);
    else passCnt++;
    step();
    idle();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b01;
    RD1E = 3; ImmExtE = 32'h20; ALUSrcE = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      totalCnt++;
      if (RegWriteM !== 0 || MemWriteM !== 0 || ResultSrcM !== 2'b00)
        $display("FAIL squash%0d got %b %b %b want 0 0 00",
                 i, RegWriteM, MemWriteM, ResultSrcM);
      else passCnt++;
      totalCnt++;
      if (ALUResultM !== 32'h23)
        $display("FAIL squash_dp%0d got %h want 00000023", i, ALUResultM);
      else passCnt++;
    end
    step();
    totalCnt++;
    if (RegWriteM !== 1 || MemWriteM !== 1 || ResultSrcM !== 2'b01)
      $display("FAIL target_instr got %b %b %b want 1 1 01",
               RegWriteM, MemWriteM, ResultSrcM);
    else passCnt++;
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    JumpE = 1; PCE = 32'h200; ImmExtE = 32'h40;
    #1;
    totalCnt++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h240)
      $display("FAIL jal got %b %h want 1 00000240", PCSrcE, PCTargetE);
    else passCnt++;
    step();
    RegWriteE = 1;
    #1;
    totalCnt++;
    if (PCSrcE !== 1'b0)
      $display("FAIL jump_in_squash1 got %b want 0", PCSrcE);
    else passCnt++;
    step();
    totalCnt++;
    if (RegWriteM !== 1'b0)
      $display("FAIL b2b_sq1 got %b want 0", RegWriteM);
    else passCnt++;
    #1;
    totalCnt++;
    if (PCSrcE !== 1'b0)
      $display("FAIL jump_in_squash2 got %b want 0", PCSrcE);
    else passCnt++;
    step();
    totalCnt++;
    if (RegWriteM !== 1'b0)
      $display("FAIL b2b_sq2 got %b want 0", RegWriteM);
    else passCnt++;
    JumpE = 0;
    step();
    totalCnt++;
    if (RegWriteM !== 1'b1)
      $display("FAIL b2b_end got %b want 1", RegWriteM);
    else passCnt++;
    idle();
  endtask

  task automatic test_wrap();
    idle();
    PCE = 32'hFFFF_FFF0; ImmExtE = 32'h20;
    #1;
    totalCnt++;
    if (PCTargetE !== 32'h0000_0010)
      $display("FAIL pc_wrap got %h want 00000010", PCTargetE);
    else passCnt++;
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUControlE = 3'b000;
    step();
    totalCnt++;
    if (ALUResultM !== 32'd0)
      $display("FAIL add_wrap got %h want 00000000", ALUResultM);
    else passCnt++;
    idle();
  endtask

  task automatic test_reset_mid_squash();
    idle();
    JumpE = 1;
    step();
    JumpE = 0; RegWriteE = 1; rst = 1;
    step();
    rst = 0;
    step();
    totalCnt++;
    if (RegWriteM !== 1'b1)
      $display("FAIL rst_mid_squash got %b want 1", RegWriteM);
    else passCnt++;
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_alu_forward();
    test_alu_ops();
    test_signed();
    test_branch_squash();
    test_back_to_back();
    test_wrap();
    test_reset_mid_squash();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
